// File: rtl/muldiv_pkg.sv
// Shared definitions for the sequential multiply/divide unit.
//   - opcode values (shared with the main ALU opcode space)
//   - FSM state and operation-class enums
//   - decode_op(): maps an opcode to its class, operand signedness and
//     which half of the result (low/quotient vs high/remainder) is returned
package muldiv_pkg;

  localparam logic [4:0] OP_MUL    = 5'b10010;
  localparam logic [4:0] OP_MULH   = 5'b10011;
  localparam logic [4:0] OP_MULHSU = 5'b10100;
  localparam logic [4:0] OP_MULHU  = 5'b10101;
  localparam logic [4:0] OP_DIV    = 5'b11000;
  localparam logic [4:0] OP_DIVU   = 5'b11001;
  localparam logic [4:0] OP_REM    = 5'b11010;
  localparam logic [4:0] OP_REMU   = 5'b11011;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  typedef enum logic [2:0] {
    CLS_NONE,
    CLS_MUL_SS,
    CLS_MUL_SU,
    CLS_MUL_UU,
    CLS_DIV_S,
    CLS_DIV_U
  } op_class_e;

  typedef struct packed {
    logic      valid;
    logic      is_div;
    logic      sel_hi;    // high product half, or remainder
    logic      a_signed;
    logic      b_signed;
    op_class_e cls;
  } op_dec_t;

  // Opcode is passed zero-extended so any OPCODE_LENGTH >= 5 decodes exactly.
  function automatic op_dec_t decode_op(input logic [31:0] op);
    op_dec_t d;
    d = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, CLS_NONE};
    case (op)
      32'(OP_MUL):    d = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, CLS_MUL_SS};
      32'(OP_MULH):   d = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, CLS_MUL_SS};
      32'(OP_MULHSU): d = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, CLS_MUL_SU};
      32'(OP_MULHU):  d = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, CLS_MUL_UU};
      32'(OP_DIV):    d = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, CLS_DIV_S};
      32'(OP_DIVU):   d = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, CLS_DIV_U};
      32'(OP_REM):    d = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, CLS_DIV_S};
      32'(OP_REMU):   d = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, CLS_DIV_U};
      default:        d = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, CLS_NONE};
    endcase
    return d;
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Iterative magnitude datapath shared by multiply and divide, one bit per step.
//   clk, reset : clock, synchronous active-high reset
//   load       : capture magnitudes and mode, clear the quotient
//   step       : perform one iteration
//   mode_div   : 1 = restoring divide, 0 = shift-add multiply (sampled on load)
//   mag_a/b    : operand magnitudes (A = multiplicand / dividend)
//   acc        : multiply -> {high, low} product; divide -> {remainder, shifted dividend}
//   quo        : quotient bits, filled from the LSB
module muldiv_iter_core #(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           load,
  input  logic           step,
  input  logic           mode_div,
  input  logic [W-1:0]   mag_a,
  input  logic [W-1:0]   mag_b,
  output logic [2*W-1:0] acc,
  output logic [W-1:0]   quo
);

  logic [W-1:0] opnd;
  logic         mode_q;
  logic [W:0]   mul_sum;
  logic [W:0]   rem_sh;
  logic [W:0]   diff;
  logic [W-1:0] rem_new;

  always_comb begin
    // Multiply: add the multiplicand when the multiplier LSB is set, then
    // shift the carry-extended sum right into the accumulator.
    mul_sum = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : {(W+1){1'b0}});
    // Divide: shift the next dividend bit into the partial remainder and
    // keep the trial difference only if it did not go negative.
    rem_sh  = acc[2*W-1:W-1];
    diff    = rem_sh - {1'b0, opnd};
    rem_new = diff[W] ? rem_sh[W-1:0] : diff[W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc    <= '0;
      quo    <= '0;
      opnd   <= '0;
      mode_q <= 1'b0;
    end else if (load) begin
      mode_q <= mode_div;
      opnd   <= mode_div ? mag_b : mag_a;
      acc    <= {{W{1'b0}}, (mode_div ? mag_a : mag_b)};
      quo    <= '0;
    end else if (step) begin
      if (mode_q) begin
        acc <= {rem_new, acc[W-2:0], 1'b0};
        quo <= {quo[W-2:0], ~diff[W]};
      end else begin
        acc <= {mul_sum, acc[W-1:1]};
      end
    end
  end

endmodule

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle RV32M multiply/divide unit with start/busy/done handshake.
//   clk, reset       : clock, synchronous active-high reset
//   start            : request, accepted when busy=0
//   flush            : abort in-flight operation (wins over start)
//   Operation        : opcode, sampled on accepted start
//   SrcA, SrcB       : operands, sampled on accepted start
//   ALUResult        : result, held between completions
//   busy             : iteration in progress
//   done             : one-cycle completion pulse
//   div_by_zero      : divide op with zero divisor, valid with done
// Optional build macro MULDIV_RESULT_CACHE_EN: keeps the last completed
// operation's operands and both result halves so a matching request
// finishes in one cycle.
//
// state | meaning
// IDLE  | waiting for start
// CALC  | DATA_WIDTH iterations of the core
// DONE  | result valid, done pulse; a new start is accepted here
module alu_muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     flush,
  input  logic [OPCODE_LENGTH-1:0] Operation,
  input  logic [DATA_WIDTH-1:0]    SrcA,
  input  logic [DATA_WIDTH-1:0]    SrcB,
  output logic [DATA_WIDTH-1:0]    ALUResult,
  output logic                     busy,
  output logic                     done,
  output logic                     div_by_zero
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

  function automatic logic [W-1:0] magnitude(input logic [W-1:0] x, input logic neg);
    return neg ? -x : x;
  endfunction

  state_e        state, state_nxt;
  logic [CW-1:0] counter;
  op_dec_t       dec;
  logic          a_neg, b_neg;
  logic          accept, load, step;
  logic          dbz, ovf, hit, fast;
  logic [W-1:0]  fast_res, hit_res;

  logic [W-1:0]  res_q;
  logic          dbz_q, from_core_q, sel_hi_q, div_q, q_neg_q, r_neg_q;

  logic [2*W-1:0] acc, prod_fx;
  logic [W-1:0]   quo, quo_fx, rem_fx, lo_fx, hi_fx;

  assign dec    = decode_op(32'(Operation));
  assign a_neg  = dec.a_signed & SrcA[W-1];
  assign b_neg  = dec.b_signed & SrcB[W-1];
  assign accept = start & ~flush & (state != CALC);

  always_comb begin
    dbz      = dec.is_div & (SrcB == '0);
    ovf      = (dec.cls == CLS_DIV_S) & (SrcA == MOST_NEG) & (SrcB == '1);
    fast     = ~dec.valid | dbz | ovf | hit;
    fast_res = '0;
    if (!dec.valid)  fast_res = '0;
    else if (dbz)    fast_res = dec.sel_hi ? SrcA : '1;
    else if (ovf)    fast_res = dec.sel_hi ? '0 : MOST_NEG;
    else if (hit)    fast_res = hit_res;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE, DONE: begin
        state_nxt = IDLE;
        if (accept) begin
          if (fast) begin
            state_nxt = DONE;
          end else begin
            state_nxt = CALC;
            load      = 1'b1;
          end
        end
      end
      CALC: begin
        step = 1'b1;
        if (counter == CW'(W-1)) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
    if (flush) begin
      state_nxt = IDLE;
      load      = 1'b0;
      step      = 1'b0;
    end
  end

  muldiv_iter_core #(.W(W)) u_core (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .step     (step),
    .mode_div (dec.is_div),
    .mag_a    (magnitude(SrcA, a_neg)),
    .mag_b    (magnitude(SrcB, b_neg)),
    .acc      (acc),
    .quo      (quo)
  );

  // Sign fix-up of the magnitude results; both halves are formed so the
  // cache can keep the one not requested.
  always_comb begin
    prod_fx = q_neg_q ? -acc : acc;
    quo_fx  = q_neg_q ? -quo : quo;
    rem_fx  = r_neg_q ? -acc[2*W-1:W] : acc[2*W-1:W];
    lo_fx   = div_q ? quo_fx : prod_fx[W-1:0];
    hi_fx   = div_q ? rem_fx : prod_fx[2*W-1:W];
  end

  // Core results are visible straight from the datapath in DONE and
  // captured into res_q on the way out, so no extra cycle is spent.
  assign ALUResult   = (state == DONE && from_core_q) ? (sel_hi_q ? hi_fx : lo_fx) : res_q;
  assign busy        = (state == CALC);
  assign done        = (state == DONE);
  assign div_by_zero = (state == DONE) & dbz_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      counter     <= '0;
      res_q       <= '0;
      dbz_q       <= 1'b0;
      from_core_q <= 1'b0;
      sel_hi_q    <= 1'b0;
      div_q       <= 1'b0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
    end else begin
      state   <= state_nxt;
      counter <= (state == CALC && state_nxt == CALC) ? counter + CW'(1) : '0;
      if (state == DONE) res_q <= ALUResult;
      if (accept) begin
        sel_hi_q    <= dec.sel_hi;
        div_q       <= dec.is_div;
        q_neg_q     <= a_neg ^ b_neg;
        r_neg_q     <= a_neg;
        dbz_q       <= dbz;
        from_core_q <= ~fast;
        if (fast) res_q <= fast_res;
      end
    end
  end

`ifdef MULDIV_RESULT_CACHE_EN
  logic      c_valid;
  logic [W-1:0] c_a, c_b, c_lo, c_hi, a_q, b_q;
  op_class_e c_cls, cls_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      c_valid <= 1'b0;
      c_a     <= '0;
      c_b     <= '0;
      c_lo    <= '0;
      c_hi    <= '0;
      c_cls   <= CLS_NONE;
      a_q     <= '0;
      b_q     <= '0;
      cls_q   <= CLS_NONE;
    end else begin
      if (accept) begin
        a_q   <= SrcA;
        b_q   <= SrcB;
        cls_q <= dec.cls;
      end
      if (flush) begin
        c_valid <= 1'b0;
      end else if (state == DONE && from_core_q) begin
        c_valid <= 1'b1;
        c_a     <= a_q;
        c_b     <= b_q;
        c_cls   <= cls_q;
        c_lo    <= lo_fx;
        c_hi    <= hi_fx;
      end
    end
  end

  assign hit     = dec.valid & c_valid & (dec.cls == c_cls) & (SrcA == c_a) & (SrcB == c_b);
  assign hit_res = dec.sel_hi ? c_hi : c_lo;
`else
  assign hit     = 1'b0;
  assign hit_res = '0;
`endif

endmodule

// File: tb/tb_alu_muldiv_seq.sv
module tb_alu_muldiv_seq;

  localparam int W = 32;
  localparam logic [4:0] T_MUL = 5'b10010, T_MULH = 5'b10011, T_MULHSU = 5'b10100, T_MULHU = 5'b10101;
  localparam logic [4:0] T_DIV = 5'b11000, T_DIVU = 5'b11001, T_REM = 5'b11010, T_REMU = 5'b11011;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [4:0]  Operation = '0;
  logic [31:0] SrcA = '0;
  logic [31:0] SrcB = '0;
  logic [31:0] ALUResult;
  logic        busy, done, div_by_zero;

  always #5 clk = ~clk;

  alu_muldiv_seq #(.DATA_WIDTH(32), .OPCODE_LENGTH(5)) dut (
    .clk(clk), .reset(reset), .start(start), .flush(flush),
    .Operation(Operation), .SrcA(SrcA), .SrcB(SrcB),
    .ALUResult(ALUResult), .busy(busy), .done(done), .div_by_zero(div_by_zero)
  );

  typedef struct {
    logic [31:0] res;
    logic        dbz;
    int          lat;
    int          busy;
    int          t0;
  } exp_t;

  exp_t        q[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          busy_cycles = 0;
  logic [31:0] last_result = '0;

`ifdef MULDIV_RESULT_CACHE_EN
  bit          c_valid = 0;
  logic [31:0] c_a, c_b;
  int          c_cls;
`endif

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int op_class(input logic [4:0] op);
    case (op)
      T_MUL, T_MULH: return 1;
      T_MULHSU:      return 2;
      T_MULHU:       return 3;
      T_DIV, T_REM:  return 4;
      T_DIVU, T_REMU: return 5;
      default:       return 0;
    endcase
  endfunction

  // Reference: plain 64-bit / 32-bit arithmetic per RV32M rules.
  task automatic model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output logic dbz, output bit fast);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'({32'd0, a});
    longint ub = longint'({32'd0, b});
    int     ia = $signed(a);
    int     ib = $signed(b);
    logic [63:0] p;
    bit     ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    res = '0; dbz = 1'b0; fast = 1'b0; p = '0;
    case (op)
      T_MUL:    begin p = sa * sb; res = p[31:0];  end
      T_MULH:   begin p = sa * sb; res = p[63:32]; end
      T_MULHSU: begin p = sa * ub; res = p[63:32]; end
      T_MULHU:  begin p = ua * ub; res = p[63:32]; end
      T_DIV:  if (b == 0) begin res = '1; dbz = 1; fast = 1; end
              else if (ovf) begin res = 32'h8000_0000; fast = 1; end
              else res = ia / ib;
      T_REM:  if (b == 0) begin res = a; dbz = 1; fast = 1; end
              else if (ovf) begin res = 0; fast = 1; end
              else res = ia % ib;
      T_DIVU: if (b == 0) begin res = '1; dbz = 1; fast = 1; end
              else res = a / b;
      T_REMU: if (b == 0) begin res = a; dbz = 1; fast = 1; end
              else res = a % b;
      default: begin res = '0; fast = 1; end
    endcase
  endtask

  task automatic model_invalidate();
`ifdef MULDIV_RESULT_CACHE_EN
    c_valid = 0;
`endif
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((q.size() != 0 || busy || done) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      tests++;
      fails++;
      $display("FAIL timeout: %0d results still pending after %0d cycles", q.size(), n);
      q.delete();
    end
  endtask

  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input bit track);
    exp_t e;
    logic [31:0] r;
    logic z;
    bit f;
    wait_idle();
    Operation = op; SrcA = a; SrcB = b; start = 1'b1;
    busy_cycles = 0;
    if (track) begin
      model(op, a, b, r, z, f);
`ifdef MULDIV_RESULT_CACHE_EN
      begin
        int cls = op_class(op);
        if (!f && c_valid && cls == c_cls && a == c_a && b == c_b) f = 1;
        else if (!f) begin c_valid = 1; c_a = a; c_b = b; c_cls = cls; end
      end
`endif
      e.res = r; e.dbz = z; e.lat = f ? 1 : W + 1; e.busy = f ? 0 : W; e.t0 = cyc;
      q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_invalidate();
    last_result = '0;
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (busy) busy_cycles++;
      if (done) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: got done=1 with result %h, required no completion", ALUResult);
        end else begin
          e = q.pop_front();
          chk("result", ALUResult, e.res);
          chk("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
          chk("latency", 32'(cyc - e.t0), 32'(e.lat));
          chk("busy_cycles", 32'(busy_cycles), 32'(e.busy));
          last_result = e.res;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0]  rop;
    logic [31:0] ra, rb;
    logic [4:0]  bad_ops[5] = '{5'b00000, 5'b10001, 5'b11100, 5'b11111, 5'b01010};

    repeat (3) @(negedge clk);
    chk("reset_result", ALUResult, 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    chk("reset_dbz", 32'(div_by_zero), 32'h0);
    reset = 1'b0;

    // Directed table
    issue(T_MUL,    32'd7,          32'hFFFF_FFFD, 1);
    issue(T_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 1);
    issue(T_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 1);
    issue(T_MULHSU, 32'hFFFF_FFFF,  32'd2,         1);
    issue(T_DIV,    32'hFFFF_FFF9,  32'd2,         1);
    issue(T_REM,    32'hFFFF_FFF9,  32'd2,         1);
    issue(T_DIVU,   32'd100,        32'd7,         1);
    issue(T_REMU,   32'd100,        32'd7,         1);
    issue(T_DIVU,   32'd5,          32'd0,         1);
    issue(T_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 1);
    issue(T_REM,    32'h8000_0000,  32'hFFFF_FFFF, 1);
    issue(5'b00111, 32'd3,          32'd4,         1);
    wait_idle();

    // Flush at cycle 10 of a DIV
    issue(T_DIV, 32'd1000, 32'd3, 0);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    model_invalidate();
    chk("flush_busy", 32'(busy), 32'h0);
    chk("flush_result", ALUResult, last_result);
    repeat (40) @(negedge clk);
    chk("flush_hold", ALUResult, last_result);

    // Start while busy is ignored
    issue(T_DIV, 32'd1000, 32'd3, 1);
    repeat (4) @(negedge clk);
    Operation = T_MUL; SrcA = 32'd5; SrcB = 32'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (5) @(negedge clk);

    // Reset mid-operation
    issue(T_MULHU, 32'h1234_5678, 32'h9ABC_DEF0, 0);
    repeat (4) @(negedge clk);
    pulse_reset();
    chk("rst_mid_result", ALUResult, last_result);
    chk("rst_mid_busy", 32'(busy), 32'h0);
    chk("rst_mid_done", 32'(done), 32'h0);
    repeat (40) @(negedge clk);
    chk("rst_mid_hold", ALUResult, last_result);

    // Back-to-back DIV/REM on same operands, then with reset in between
    issue(T_DIV, 32'd100, 32'd7, 1);
    issue(T_REM, 32'd100, 32'd7, 1);
    issue(T_DIV, 32'd100, 32'd7, 1);
    wait_idle();
    pulse_reset();
    issue(T_REM, 32'd100, 32'd7, 1);

    // Random operations
    for (int i = 0; i < 40; i++) begin
      int k = $urandom_range(0, 9);
      case (k)
        0: rop = T_MUL;   1: rop = T_MULH;  2: rop = T_MULHSU; 3: rop = T_MULHU;
        4: rop = T_DIV;   5: rop = T_DIVU;  6: rop = T_REM;    7: rop = T_REMU;
        default: rop = (k == 8) ? bad_ops[$urandom_range(0, 4)] : T_DIV;
      endcase
      case ($urandom_range(0, 5))
        0: ra = 32'h0; 1: ra = 32'hFFFF_FFFF; 2: ra = 32'h8000_0000;
        3: ra = $urandom_range(0, 20); default: ra = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: rb = 32'h0; 1: rb = 32'hFFFF_FFFF; 2: rb = 32'h8000_0000;
        3: rb = $urandom_range(0, 20); default: rb = $urandom;
      endcase
      issue(rop, ra, rb, 1);
    end
    wait_idle();
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
